uart_tx_rx_monitor: RTL

//   Serial receiver/decoder on the SoC UART_TX pin, downstream of krv_e.

---
 rtl/uart_tx_rx_monitor.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_rx_monitor.sv
// uart_tx_rx_monitor
//   Receives the 8N1 byte stream on the SoC UART_TX pin and rebuilds the bytes
//   into a small FIFO that is drained with a valid/ready handshake. Framing
//   errors and FIFO overflow are flagged so software pass/fail text can be
//   checked in hardware.
// Ports
//   cpu_clk    : clock, all flops on the rising edge
//   porn       : asynchronous active-low reset
//   uart_line  : serial input, idle high
//   rx_data    : registered byte at the FIFO head
//   rx_valid   : FIFO not empty
//   rx_ready   : consumer accepts rx_data (pop on rx_valid & rx_ready)
//   fifo_level : number of bytes held
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   overflow   : sticky, set when a byte arrives while the FIFO is full
//   clr_ovf    : synchronous clear of overflow (a same-cycle set wins)
//   byte_cnt   : count of good bytes received, wraps
module uart_tx_rx_monitor #(
  parameter int unsigned BAUD_DIV   = 217,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          cpu_clk,
  input  logic                          porn,
  input  logic                          uart_line,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [15:0]                   byte_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state, state_next;
  logic        sync1, line_s;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic cnt_clr, idx_clr, shift_en, push_req, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0] count;
  logic          full, pop, do_push;

  // Two-flop synchronizer, idle-high reset so reset never looks like a start bit
  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) begin
      sync1  <= 1'b1;
      line_s <= 1'b1;
    end else begin
      sync1  <= uart_line;
      line_s <= sync1;
    end
  end

  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    shift_en   = 1'b0;
    push_req   = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!line_s) state_next = START;
      end
      START: begin
        if (bit_cnt == HALF_M1) begin
          cnt_clr    = 1'b1;
          idx_clr    = 1'b1;
          state_next = line_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (line_s) begin
            push_req   = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        // Stay here while the line is low so a held-low line cannot frame again
        cnt_clr = 1'b1;
        if (line_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      bit_cnt   <= cnt_clr ? '0 : bit_cnt + 16'd1;
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en)      shreg   <= {line_s, shreg[7:1]};
      frame_err <= ferr_set;
      if (push_req)      byte_cnt <= byte_cnt + 16'd1;
    end
  end

  assign full       = (count == CW'(FIFO_DEPTH));
  assign rx_valid   = (count != '0);
  assign fifo_level = count;
  assign pop        = rx_valid & rx_ready;
  assign do_push    = push_req & (~full | pop);
  assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge cpu_clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge cpu_clk or negedge porn) begin
    if (!porn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Registered head: when the new head slot is the one being written this
      // cycle (FIFO empty, or one entry popped), forward the incoming byte.
      if (do_push && (wr_ptr == rd_next)) rx_data <= shreg;
      else                                rx_data <= mem[rd_next];
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)             overflow <= 1'b0;
    end
  end

endmodule
